// File: rtl/bounded_counter.sv
// bounded_counter: parametrised up/down counter with saturate, wrap or bounce
// behaviour at its bounds, clamped synchronous load and registered tc/ovf flags.
module bounded_counter #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 3,
  parameter int MAX_VAL = 12,
  parameter int MODE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             dir_q,
  output logic             at_min,
  output logic             at_max,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH:0]   MIN_E = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_E = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  logic [WIDTH-1:0] r_count;
  logic             r_bdir;
  logic             r_tc;
  logic             r_ovf;
  logic [WIDTH:0]   w_cnt;
  logic [WIDTH:0]   w_lv;
  logic [WIDTH:0]   w_next;
  logic [WIDTH:0]   w_tgt;
  logic [WIDTH-1:0] w_clamp;
  logic             w_up;
  logic             w_edge;
  logic             w_step;
  // one extra bit of headroom keeps +1/-1 from silently wrapping at 2^WIDTH-1
  always_comb begin
    w_cnt   = {1'b0, r_count};
    w_lv    = {1'b0, load_val};
    w_up    = (MODE == 2) ? r_bdir : dir;
    w_step  = en & ~load;
    w_edge  = w_up ? (w_cnt == MAX_E) : (w_cnt == MIN_E);
    w_tgt   = w_up ? MAX_E : MIN_E;
    w_next  = !w_edge   ? (w_up ? w_cnt + ONE : w_cnt - ONE) :
              MODE == 0 ? w_cnt :
              MODE == 1 ? (w_up ? MIN_E : MAX_E) :
                          (w_up ? w_cnt - ONE : w_cnt + ONE);
    w_clamp = (w_lv < MIN_E) ? MIN_W : (w_lv > MAX_E) ? MAX_W : load_val;
  end
  // a step taken at the bound (hold, wrap or reflect) never raises tc
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= MIN_W;
      r_bdir  <= 1'b1;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= load ? w_clamp : w_step ? w_next[WIDTH-1:0] : r_count;
      r_bdir  <= (MODE == 2 && w_step && w_edge) ? ~r_bdir : r_bdir;
      r_tc    <= w_step & ~w_edge & (w_next == w_tgt);
      r_ovf   <= (r_ovf & ~clr_ovf) | (w_step & w_edge & (MODE != 2));
    end
  end
  assign count  = r_count;
  assign dir_q  = w_up;
  assign at_min = (r_count == MIN_W);
  assign at_max = (r_count == MAX_W);
  assign tc     = r_tc;
  assign ovf    = r_ovf;
endmodule

// File: tb/tb_bounded_counter.sv
// tb_bounded_counter: directed vector table for saturate mode plus hand-written
// sequences for wrap, bounce, reset priority and an 8-bit full-range wrap sweep.
module tb_bounded_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, en, dir, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] cnt [3];
  logic       dq [3], amin [3], amax [3], tcs [3], ov [3];
  for (genvar k = 0; k < 3; k++) begin : g_dut
    bounded_counter #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(12), .MODE(k)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt[k]), .dir_q(dq[k]),
      .at_min(amin[k]), .at_max(amax[k]), .tc(tcs[k]), .ovf(ov[k])
    );
  end
  logic       w_rst_n, w_en, w_dir, w_load, w_clr;
  logic [7:0] w_lv, w_cnt;
  logic       w_dq, w_amin, w_amax, w_tc, w_ovf;
  bounded_counter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .MODE(1)) u_w8 (
    .clk(clk), .rst_n(w_rst_n), .en(w_en), .dir(w_dir), .load(w_load),
    .load_val(w_lv), .clr_ovf(w_clr), .count(w_cnt), .dir_q(w_dq),
    .at_min(w_amin), .at_max(w_amax), .tc(w_tc), .ovf(w_ovf)
  );
  int n_pass = 0;
  int n_total = 0;
  typedef struct {
    logic rn, en, dir, ld;
    logic [3:0] lv;
    logic clr;
    logic [3:0] cnt;
    logic tc, ovf;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic rn_i, en_i, dir_i, ld_i, logic [3:0] lv_i, logic clr_i,
                              logic [3:0] cnt_i, logic tc_i, ovf_i);
    vec_t r;
    r.rn = rn_i; r.en = en_i; r.dir = dir_i; r.ld = ld_i; r.lv = lv_i; r.clr = clr_i;
    r.cnt = cnt_i; r.tc = tc_i; r.ovf = ovf_i;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic drive(input logic rn_i, en_i, dir_i, ld_i, input logic [3:0] lv_i, input logic clr_i);
    rst_n = rn_i; en = en_i; dir = dir_i; load = ld_i; load_val = lv_i; clr_ovf = clr_i;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
    w_rst_n = 1'b0; w_en = 1'b0; w_dir = 1'b1; w_load = 1'b0; w_lv = '0; w_clr = 1'b0;
    // saturate mode: up to 12 and hold, down to 3 and hold, then load/reset cases
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0));
    for (int i = 4; i <= 12; i++) vecs.push_back(mk(1, 1, 1, 0, 0, 0, 4'(i), i == 12, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12, 0, 1));
    for (int i = 11; i >= 3; i--) vecs.push_back(mk(1, 1, 0, 0, 0, 0, 4'(i), i == 3, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 15, 0, 12, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 7, 0, 7, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 8, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 8, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 9, 0, 9, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 5, 0, 3, 0, 0));
    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].en, vecs[i].dir, vecs[i].ld, vecs[i].lv, vecs[i].clr);
      chk($sformatf("sat[%0d].count", i), 32'(cnt[0]), 32'(vecs[i].cnt));
      chk($sformatf("sat[%0d].tc", i), 32'(tcs[0]), 32'(vecs[i].tc));
      chk($sformatf("sat[%0d].ovf", i), 32'(ov[0]), 32'(vecs[i].ovf));
      chk($sformatf("sat[%0d].at_min", i), 32'(amin[0]), 32'(vecs[i].cnt == 4'd3));
      chk($sformatf("sat[%0d].at_max", i), 32'(amax[0]), 32'(vecs[i].cnt == 4'd12));
      chk($sformatf("sat[%0d].dir_q", i), 32'(dq[0]), 32'(vecs[i].dir));
    end
    // wrap mode
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 1, 11, 0);
    chk("wrap.load11", 32'(cnt[1]), 32'd11);
    drive(1, 1, 1, 0, 0, 0);
    chk("wrap.cnt12", 32'(cnt[1]), 32'd12);
    chk("wrap.tc12", 32'(tcs[1]), 32'd1);
    chk("wrap.ovf_pre", 32'(ov[1]), 32'd0);
    drive(1, 1, 1, 0, 0, 0);
    chk("wrap.cnt3", 32'(cnt[1]), 32'd3);
    chk("wrap.ovf_set", 32'(ov[1]), 32'd1);
    chk("wrap.no_tc_at3", 32'(tcs[1]), 32'd0);
    for (int i = 4; i <= 12; i++) begin
      drive(1, 1, 1, 0, 0, 0);
      chk($sformatf("wrap.up%0d", i), 32'(cnt[1]), 32'(i));
    end
    drive(1, 1, 1, 0, 0, 1);
    chk("wrap.clr_and_wrap.cnt", 32'(cnt[1]), 32'd3);
    chk("wrap.clr_and_wrap.ovf", 32'(ov[1]), 32'd1);
    drive(1, 0, 1, 0, 0, 1);
    chk("wrap.clr.ovf", 32'(ov[1]), 32'd0);
    drive(1, 1, 0, 0, 0, 0);
    chk("wrap.down.cnt", 32'(cnt[1]), 32'd12);
    chk("wrap.down.ovf", 32'(ov[1]), 32'd1);
    chk("wrap.down.tc", 32'(tcs[1]), 32'd0);
    // bounce mode, dir input held low to show it is ignored
    drive(0, 0, 0, 0, 0, 0);
    chk("bnc.rst.dir_q", 32'(dq[2]), 32'd1);
    for (int i = 0; i < 19; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      chk($sformatf("bnc[%0d].count", i), 32'(cnt[2]),
          i <= 8 ? 32'(4 + i) : i <= 17 ? 32'(20 - i) : 32'd4);
      chk($sformatf("bnc[%0d].dir_q", i), 32'(dq[2]), 32'(i <= 8 || i == 18));
      chk($sformatf("bnc[%0d].tc", i), 32'(tcs[2]), 32'(i == 8 || i == 17));
      chk($sformatf("bnc[%0d].ovf", i), 32'(ov[2]), 32'd0);
    end
    for (int i = 0; i < 9; i++) drive(1, 1, 0, 0, 0, 0);
    chk("bnc.pre_rst.count", 32'(cnt[2]), 32'd11);
    chk("bnc.pre_rst.dir_q", 32'(dq[2]), 32'd0);
    drive(0, 1, 1, 1, 9, 0);
    chk("bnc.rst.count", 32'(cnt[2]), 32'd3);
    chk("bnc.rst.dir_up", 32'(dq[2]), 32'd1);
    chk("bnc.rst.tc", 32'(tcs[2]), 32'd0);
    // 8-bit full-range wrap sweep
    w_rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("w8.rst", 32'(w_cnt), 32'd0);
    w_rst_n = 1'b1; w_en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w8[%0d].count", i), 32'(w_cnt), 32'(i % 256));
      chk($sformatf("w8[%0d].ovf", i), 32'(w_ovf), 32'(i == 256));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
